// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each accepted request runs IDLE -> EXEC -> RESP and yields a registered response.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ReqValid0,
    output logic             ReqReady0,
    input  logic [2:0]       ReqOp0,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqB0,

    input  logic             ReqValid1,
    output logic             ReqReady1,
    input  logic [2:0]       ReqOp1,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB1,

    output logic             RspValid,
    input  logic             RspReady,
    output logic             RspId,
    output logic [WIDTH-1:0] RspResult,
    output logic             RspZero,
    output logic             RspSign,

    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             ZeroFlag,
    input  logic             SignFlag
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic             last_grant_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_sign_q;

    logic grant0;
    logic grant1;

    // Grants already include ReqValid, so a grant is the request handshake itself.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && state_q == StIdle) begin
            if (ReqValid0 && ReqValid1) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = ReqValid0;
                grant1 = ReqValid1;
            end
        end
    end

    assign ReqReady0 = grant0;
    assign ReqReady1 = grant1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_sign_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant0) begin
                        op_q         <= ReqOp0;
                        a_q          <= ReqA0;
                        b_q          <= ReqB0;
                        last_grant_q <= 1'b0;
                        rsp_id_q     <= 1'b0;
                        state_q      <= StExec;
                    end else if (grant1) begin
                        op_q         <= ReqOp1;
                        a_q          <= ReqA1;
                        b_q          <= ReqB1;
                        last_grant_q <= 1'b1;
                        rsp_id_q     <= 1'b1;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_result_q <= ALUResult;
                    rsp_zero_q   <= ZeroFlag;
                    rsp_sign_q   <= SignFlag;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Operand registers persist after the response so the ALU inputs stay quiet in IDLE.
    assign SrcA       = a_q;
    assign SrcB       = b_q;
    assign ALUControl = op_q;

    assign RspValid   = rsp_valid_q;
    assign RspId      = rsp_id_q;
    assign RspResult  = rsp_result_q;
    assign RspZero    = rsp_zero_q;
    assign RspSign    = rsp_sign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a stand-in ALU and a
// transaction-level reference model of grant order and results.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         ReqValid0, ReqReady0, ReqValid1, ReqReady1;
    logic [2:0]   ReqOp0, ReqOp1;
    logic [W-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
    logic         RspValid, RspReady, RspId, RspZero, RspSign;
    logic [W-1:0] RspResult, SrcA, SrcB, ALUResult;
    logic [2:0]   ALUControl;
    logic         ZeroFlag, SignFlag;

    int n_total = 0;
    int n_bad   = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ReqValid0 (ReqValid0),
        .ReqReady0 (ReqReady0),
        .ReqOp0    (ReqOp0),
        .ReqA0     (ReqA0),
        .ReqB0     (ReqB0),
        .ReqValid1 (ReqValid1),
        .ReqReady1 (ReqReady1),
        .ReqOp1    (ReqOp1),
        .ReqA1     (ReqA1),
        .ReqB1     (ReqB1),
        .RspValid  (RspValid),
        .RspReady  (RspReady),
        .RspId     (RspId),
        .RspResult (RspResult),
        .RspZero   (RspZero),
        .RspSign   (RspSign),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUControl(ALUControl),
        .ALUResult (ALUResult),
        .ZeroFlag  (ZeroFlag),
        .SignFlag  (SignFlag)
    );

    always #5 clk = ~clk;

    // Op encoding of the stand-in ALU; 3'b011 is undefined and yields zero.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a << b[4:0];
            3'd7:    return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    assign ALUResult = ref_alu(ALUControl, SrcA, SrcB);
    assign ZeroFlag  = (ALUResult == '0);
    assign SignFlag  = ALUResult[W-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            ReqValid1 = v; ReqOp1 = op; ReqA1 = a; ReqB1 = b;
        end else begin
            ReqValid0 = v; ReqOp0 = op; ReqA0 = a; ReqB0 = b;
        end
    endtask

    // Entered one cycle after acceptance (EXEC); leaves one cycle after the response handshake.
    task automatic finish_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp, input int stall);
        chk("exec_src_a", SrcA, a);
        chk("exec_src_b", SrcB, b);
        chk("exec_alu_ctl", 32'(op), 32'(op));
        chk("exec_alu_ctl_drv", 32'(ALUControl), 32'(op));
        chk("exec_rsp_valid", 32'(RspValid), 32'd0);
        chk("exec_no_grant", 32'({ReqReady1, ReqReady0}), 32'd0);
        cyc();
        for (int i = 0; i <= stall; i++) begin
            RspReady = (i == stall);
            #1;
            chk("rsp_valid", 32'(RspValid), 32'd1);
            chk("rsp_id", 32'(RspId), 32'(id));
            chk("rsp_result", RspResult, exp);
            chk("rsp_zero", 32'(RspZero), 32'(exp == '0));
            chk("rsp_sign", 32'(RspSign), 32'(exp[W-1]));
            chk("resp_no_grant", 32'({ReqReady1, ReqReady0}), 32'd0);
            cyc();
        end
        RspReady = 1'b0;
        chk("rsp_cleared", 32'(RspValid), 32'd0);
        chk("idle_src_hold", SrcA, a);
    endtask

    task automatic run_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int stall);
        drive(id, 1'b1, op, a, b);
        #1;
        chk("grant_single", 32'({ReqReady1, ReqReady0}), id ? 32'd2 : 32'd1);
        cyc();
        drive(id, 1'b0, 3'd0, '0, '0);
        finish_op(id, op, a, b, exp, stall);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         model_last;
        logic [W-1:0] rsp_res[4];
        logic         rsp_id[4];
        logic         rsp_sign[4];
        int           rsp_cyc[4];
        int           cnt;

        // Reset state, with both requesters asserting during reset.
        rst = 1'b0;
        RspReady = 1'b0;
        drive(1'b0, 1'b1, 3'd5, 32'h1234, 32'h5678);
        drive(1'b1, 1'b1, 3'd6, 32'h9abc, 32'hdef0);
        #3;
        chk("reset_ready", 32'({ReqReady1, ReqReady0}), 32'd0);
        chk("reset_rsp_valid", 32'(RspValid), 32'd0);
        chk("reset_rsp_id", 32'(RspId), 32'd0);
        chk("reset_rsp_result", RspResult, 32'd0);
        chk("reset_rsp_flags", 32'({RspZero, RspSign}), 32'd0);
        chk("reset_src_a", SrcA, 32'd0);
        chk("reset_src_b", SrcB, 32'd0);
        chk("reset_alu_ctl", 32'(ALUControl), 32'd0);
        drive(1'b0, 1'b0, 3'd0, '0, '0);
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        cyc();
        rst = 1'b1;
        cyc();

        // Single ADD from requester 0.
        run_op(1'b0, 3'd0, 32'd5, 32'd7, 32'd12, 0);

        // Contention from a fresh reset: requester 0 must win first, then strict alternation.
        do_reset();
        drive(1'b0, 1'b1, 3'd5, 32'hF0F0F0F0, 32'h0F0F0F0F);
        drive(1'b1, 1'b1, 3'd5, 32'hF0F0F0F0, 32'h0F0F0F0F);
        RspReady = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < 4; c++) begin
            #1;
            if (RspValid) begin
                rsp_res[cnt]  = RspResult;
                rsp_id[cnt]   = RspId;
                rsp_sign[cnt] = RspSign;
                rsp_cyc[cnt]  = c;
                cnt++;
            end
            cyc();
        end
        drive(1'b0, 1'b0, 3'd0, '0, '0);
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        RspReady = 1'b0;
        chk("contention_count", 32'(cnt), 32'd4);
        for (int i = 0; i < cnt; i++) begin
            chk("contention_id", 32'(rsp_id[i]), 32'(i % 2));
            chk("contention_result", rsp_res[i], 32'hFFFFFFFF);
            chk("contention_sign", 32'(rsp_sign[i]), 32'd1);
            if (i > 0) chk("contention_spacing", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
        end
        cyc();

        // Flags from requester 1.
        run_op(1'b1, 3'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 0);
        run_op(1'b1, 3'd1, 32'd9, 32'd9, 32'd0, 0);

        // Backpressure: requester 1 waits through a 5-cycle stall, then wins next.
        drive(1'b1, 1'b1, 3'd0, 32'd100, 32'd23);
        run_op(1'b0, 3'd6, 32'd1, 32'd4, 32'd16, 5);
        chk("bp_next_grant", 32'({ReqReady1, ReqReady0}), 32'd2);
        cyc();
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        finish_op(1'b1, 3'd0, 32'd100, 32'd23, 32'd123, 0);

        // Undefined op passes through; stand-in ALU returns zero.
        run_op(1'b0, 3'd3, 32'd1, 32'd2, 32'd0, 0);

        // Reset during EXEC discards the transaction.
        drive(1'b1, 1'b1, 3'd4, 32'h00FF0000, 32'h000000FF);
        #1;
        chk("mid_grant", 32'({ReqReady1, ReqReady0}), 32'd2);
        cyc();
        chk("mid_in_exec", 32'(RspId), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_ready", 32'({ReqReady1, ReqReady0}), 32'd0);
        chk("mid_reset_src_a", SrcA, 32'd0);
        chk("mid_reset_src_b", SrcB, 32'd0);
        chk("mid_reset_ctl", 32'(ALUControl), 32'd0);
        chk("mid_reset_rsp_id", 32'(RspId), 32'd0);
        chk("mid_reset_rsp_valid", 32'(RspValid), 32'd0);
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        cyc();
        rst = 1'b1;
        RspReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mid_no_response", 32'(RspValid), 32'd0);
            cyc();
        end
        RspReady = 1'b0;
        drive(1'b0, 1'b1, 3'd2, 32'hFFFF00FF, 32'h0F0F0F0F);
        drive(1'b1, 1'b1, 3'd7, 32'h80000000, 32'd4);
        #1;
        chk("post_reset_tie", 32'({ReqReady1, ReqReady0}), 32'd1);
        cyc();
        drive(1'b0, 1'b0, 3'd0, '0, '0);
        drive(1'b1, 1'b0, 3'd0, '0, '0);
        finish_op(1'b0, 3'd2, 32'hFFFF00FF, 32'h0F0F0F0F, 32'h0F0F000F, 0);

        // Random traffic against the transaction-level model.
        model_last = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int           v;
            logic         g;
            logic [2:0]   op[2];
            logic [W-1:0] a[2];
            logic [W-1:0] b[2];
            v = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                op[r] = 3'($urandom_range(0, 7));
                a[r]  = $urandom;
                b[r]  = ($urandom_range(0, 3) == 0) ? a[r] : $urandom;
            end
            drive(1'b0, v[0], op[0], a[0], b[0]);
            drive(1'b1, v[1], op[1], a[1], b[1]);
            g = (v == 3) ? ~model_last : (v == 2);
            #1;
            chk("rand_grant", 32'({ReqReady1, ReqReady0}), g ? 32'd2 : 32'd1);
            cyc();
            model_last = g;
            drive(1'b0, 1'b0, 3'd0, '0, '0);
            drive(1'b1, 1'b0, 3'd0, '0, '0);
            finish_op(g, op[g], a[g], b[g], ref_alu(op[g], a[g], b[g]),
                      int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, such as the integer pipeline and a debug/scan port, and gives each request a registered result. It uses a round-robin grant, a valid/ready handshake on both the request and response sides, and a 3-state FSM. It sits between the requesters and the ALU and fully owns the ALU's SrcA/SrcB/ALUControl inputs.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ReqValid0  in  1  requester 0 has an operation pending.
- ReqReady0  out  1  requester 0's request is accepted this cycle.
- ReqOp0  in  3  ALUControl code for requester 0.
- ReqA0  in  WIDTH  operand A for requester 0.
- ReqB0  in  WIDTH  operand B for requester 0.
- ReqValid1, ReqReady1, ReqOp1, ReqA1, ReqB1: the same signals for requester 1.
- RspValid  out  1  a response is held on Rsp*.
- RspReady  in  1  the consumer takes the response.
- RspId  out  1  index of the requester that owns the response.
- RspResult  out  WIDTH  registered ALUResult.
- RspZero  out  1  registered ZeroFlag.
- RspSign  out  1  registered SignFlag.
- SrcA  out  WIDTH  drives ALU SrcA.
- SrcB  out  WIDTH  drives ALU SrcB.
- ALUControl  out  3  drives ALU ALUControl.
- ALUResult  in  WIDTH  from the ALU.
- ZeroFlag  in  1  from the ALU.
- SignFlag  in  1  from the ALU.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - Grant rules:
    - If exactly one ReqValid is high, grant that requester.
    - If both are high, grant the requester that is not LastGrant.
  - ReqReadyN is high combinationally only in IDLE, only for the granted requester. The other ReqReady stays low.
  - On the edge where ReqValidN & ReqReadyN: latch ReqOpN/ReqAN/ReqBN into the operand registers, set LastGrant=N, set RspId=N, and go to EXEC.
  - With no request, stay in IDLE.
- **EXEC**
  - SrcA/SrcB/ALUControl are driven from the operand registers. They are always registered outputs, never combinational passthrough of Req*.
  - On the edge: capture ALUResult/ZeroFlag/SignFlag into RspResult/RspZero/RspSign, set RspValid=1, and go to RESP.
- **RESP**
  - RspValid stays 1. All Rsp* outputs stay stable until RspReady=1.
  - On the handshake edge: clear RspValid and go to IDLE.
  - No new grant is given in RESP or EXEC.
- Operand registers keep their values after the response. The ALU inputs therefore do not toggle while idle.
- Undefined op code 3'b011 is passed through unchanged. The ALU returns 0, so RspResult=0 and RspZero=1. The arbiter does not flag an error.
- Withdrawing a request:
  - A requester may drop ReqValid at any time before its handshake; nothing is latched.
  - Once accepted, the transaction always completes.
- Reset is asserted asynchronously in any state. The in-flight transaction is discarded and no response is issued.

## Timing
- Reset values:
  - FSM = IDLE; LastGrant = 1, so requester 0 wins the first tie.
  - ReqReady0 = ReqReady1 = 0 while rst is low.
  - RspValid = 0, RspId = 0, RspResult = 0, RspZero = 0, RspSign = 0.
  - SrcA = 0, SrcB = 0, ALUControl = 3'b000.
- Latency: request accepted at edge E0 → operands on SrcA/SrcB/ALUControl after E0 → RspValid=1 after E0+1. That is 2 cycles from acceptance to response.
- Throughput: with RspReady held high, one operation every 3 cycles (IDLE, EXEC, RESP). The next ReqReady comes in the cycle after the response handshake.
- Backpressure: every cycle RspReady stays low adds one cycle in RESP. There is no limit.
- Fairness: under constant contention, grants alternate 0,1,0,1. No requester waits for more than one other transaction.
- The ALU must settle within one clk period; the EXEC capture is single-cycle.

## Test plan
- **Single request, ADD.** Reset, then ReqValid0=1, ReqOp0=000, A=5, B=7. Expect: ReqReady0 high in the first IDLE cycle; two edges after acceptance RspValid=1, RspId=0, RspResult=12, RspZero=0, RspSign=0.
- **Contention.** Both ReqValid held high with RspReady=1, each issuing XOR 0xF0F0F0F0^0x0F0F0F0F. Expect: RspId sequence 0,1,0,1; every RspResult=0xFFFFFFFF with RspSign=1; responses 3 cycles apart.
- **Flags.** Requester 1 SUB 3−5. Expect RspResult=0xFFFFFFFE, RspSign=1, RspZero=0. Then SUB 9−9. Expect RspResult=0, RspZero=1, RspSign=0.
- **Backpressure.** Requester 0 SHL 1<<4, RspReady low for 5 cycles, ReqValid1 high throughout. Expect: RspValid and RspResult=16 stable for all 5 cycles; ReqReady1=0 for all 5 cycles; requester 1 granted in the cycle after the handshake.
- **Reset mid-operation.** Assert rst low during EXEC. Expect: all outputs immediately take their reset values; after release no response appears; a new request is accepted with requester 0 first on a tie.
- **Undefined op.** ReqOp0=011, A=1, B=2. Expect RspResult=0, RspZero=1, RspSign=0, with normal 2-cycle latency.
